// File: rtl/tone_synth_poly_sel.sv
// tone_synth_poly_sel: multi-key square-wave tone synthesizer.
// Synchronises and debounces NUM_KEYS active-low buttons. It picks one
// sounding key by priority mode, applies a runtime octave shift and drives
// a 50% duty square wave.
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   btn_n    raw active-low buttons (asynchronous to clk)
//   octave   right-shift applied to the half period (0..3)
//   speaker  square-wave output (registered)
//   active   a note is sounding (registered)
//   key_idx  index of the sounding key; holds its value when inactive
module tone_synth_poly_sel #(
  parameter int unsigned NUM_KEYS        = 8,
  parameter int unsigned CNT_W           = 20,
  parameter logic [NUM_KEYS*CNT_W-1:0] HALF_PERIODS = {
    20'd95557, 20'd101239, 20'd113636, 20'd127551,
    20'd143172, 20'd151685, 20'd170265, 20'd191110},
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned PRIORITY_MODE   = 0,
  localparam int unsigned KEY_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] btn_n,
  input  logic [1:0]          octave,
  output logic                speaker,
  output logic                active,
  output logic [KEY_W-1:0]    key_idx
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1, sync2, s, db, db_prev, rising;
  logic [DB_W-1:0]     db_cnt [NUM_KEYS];
  logic [CNT_W-1:0]    hp_table [NUM_KEYS];
  logic [CNT_W-1:0]    hp_shift, hp, cnt, cnt_next;
  logic                phase, phase_next, active_next, start;
  logic [KEY_W-1:0]    key_next;

  // Lowest set bit of a key vector (0 when empty).
  function automatic logic [KEY_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] v);
    lowest_set = '0;
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = KEY_W'(i);
    end
  endfunction

  // Two-flop synchroniser on the raw (active-low) buttons; reset = released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  // Per-key debounce: accept a change after DEBOUNCE_CYCLES stable cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db <= '0;
      for (int i = 0; i < int'(NUM_KEYS); i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        if (s[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= s[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign rising = db & ~db_prev;

  // Key selection.
  always_comb begin
    active_next = |db;
    key_next    = key_idx;
    if (|db) begin
      if (PRIORITY_MODE == 0) begin
        key_next = lowest_set(db);
      end else if (|rising) begin
        key_next = lowest_set(rising);
      end else if (!db[key_idx]) begin
        key_next = lowest_set(db);
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_KEYS); g++) begin : g_tab
    assign hp_table[g] = HALF_PERIODS[g*CNT_W +: CNT_W];
  end

  // Shifted half period, clamped to at least one cycle.
  always_comb begin
    hp_shift = hp_table[key_idx] >> octave;
    hp       = (hp_shift == '0) ? CNT_W'(1) : hp_shift;
  end

  // Tone generator; the >= compare lets a shrinking hp toggle on the next edge.
  always_comb begin
    start      = active_next && (!active || (key_next != key_idx));
    cnt_next   = cnt + CNT_W'(1);
    phase_next = phase;
    if (!active_next || start) begin
      cnt_next   = '0;
      phase_next = 1'b0;
    end else if (cnt >= hp - CNT_W'(1)) begin
      cnt_next   = '0;
      phase_next = ~phase;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_prev <= '0;
      active  <= 1'b0;
      key_idx <= '0;
      cnt     <= '0;
      phase   <= 1'b0;
      speaker <= 1'b0;
    end else begin
      db_prev <= db;
      active  <= active_next;
      key_idx <= key_next;
      cnt     <= cnt_next;
      phase   <= phase_next;
      speaker <= phase_next & active_next;
    end
  end

endmodule
